// File: rtl/aexm_dcache_resp.sv
// ---------------------------------------------------------------------------
// aexm_dcache_resp
//
// Cache-side responder for the core's data precycle interface.
// Direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
// Read hits are answered with zero stall. Read misses are filled over a
// req/ack memory port. Writes always go to memory, and a line that is
// already resident is updated as well.
//
// Ports:
//   sys_clk_i                    clock, rising edge
//   sys_rst_i                    synchronous reset, active low
//   aexm_dcache_precycle_addr    byte address of the next data phase
//   aexm_dcache_precycle_enable  request presented this cycle
//   aexm_dcache_precycle_we      request is a write
//   aexm_dcache_force_miss       treat a read as a miss
//   aexm_dcache_datao            write data, sampled in the data phase
//   aexm_dcache_datai            read data, valid when cache_busy = 0
//   aexm_dcache_cache_busy       stall for the core's data phase
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_rdata/mem_ack            memory response, ack is a one-cycle pulse
// ---------------------------------------------------------------------------
module aexm_dcache_resp #(
  parameter int IDX_W = 6,
  parameter int AW    = 32
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [31:0]   aexm_dcache_precycle_addr,
  input  logic          aexm_dcache_precycle_enable,
  input  logic          aexm_dcache_precycle_we,
  input  logic          aexm_dcache_force_miss,
  input  logic [31:0]   aexm_dcache_datao,
  output logic [31:0]   aexm_dcache_datai,
  output logic          aexm_dcache_cache_busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = AW - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Control and request registers
  state_e           state_q;
  logic             req_v_q;
  logic [AW-1:2]    req_addr_q;
  logic             req_we_q;
  logic             req_fm_q;
  logic [31:0]      wbuf_q;
  logic [31:0]      rdata_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [LINES-1:0] valid_q;

  // Storage arrays; these are deliberately not reset (valid_q guards them)
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Decoded request fields
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             line_match_s;
  logic             rd_hit_s;
  logic             busy_s;
  logic [31:0]      datai_s;

  // Array write port
  logic             arr_we_s;
  logic             arr_tag_we_s;
  logic [31:0]      arr_wdata_s;

  // Byte-offset bits carry no information for a word-only cache
  logic             unused_addr_s;
  assign unused_addr_s = ^aexm_dcache_precycle_addr[1:0];

  assign idx_s = req_addr_q[IDX_W+1:2];
  assign tag_s = req_addr_q[AW-1:IDX_W+2];

  // Hit detection. Writes update a resident line regardless of force_miss,
  // so the cached copy never goes stale behind a write-through.
  always_comb begin
    line_match_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    rd_hit_s     = req_v_q && !req_we_q && !req_fm_q && line_match_s;
  end

  // Stall and read-data outputs, derived only from registered state and array reads
  always_comb begin
    busy_s  = 1'b0;
    datai_s = rdata_q;
    case (state_q)
      ST_IDLE: begin
        busy_s = req_v_q && !rd_hit_s;
        if (rd_hit_s) begin
          datai_s = data_q[idx_s];
        end else begin
          datai_s = rdata_q;
        end
      end
      ST_FILL:  busy_s = 1'b1;
      ST_WRITE: busy_s = 1'b1;
      ST_DONE:  busy_s = 1'b0;
      default:  busy_s = 1'b0;
    endcase
  end

  assign aexm_dcache_cache_busy = busy_s;
  assign aexm_dcache_datai      = datai_s;
  assign mem_req                = mem_req_q;
  assign mem_we                 = mem_we_q;
  assign mem_addr               = mem_addr_q;
  assign mem_wdata              = wbuf_q;

  // Array write selection: a write hit in the data phase, or fill completion
  always_comb begin
    arr_we_s     = 1'b0;
    arr_tag_we_s = 1'b0;
    arr_wdata_s  = aexm_dcache_datao;
    if (!sys_rst_i) begin
      arr_we_s = 1'b0;
    end else if ((state_q == ST_FILL) && mem_ack) begin
      arr_we_s     = 1'b1;
      arr_tag_we_s = 1'b1;
      arr_wdata_s  = mem_rdata;
    end else if ((state_q == ST_IDLE) && req_v_q && req_we_q && line_match_s) begin
      arr_we_s = 1'b1;
    end else begin
      arr_we_s = 1'b0;
    end
  end

  // Tag and data array storage
  always_ff @(posedge sys_clk_i) begin
    if (arr_we_s) begin
      data_q[idx_s] <= arr_wdata_s;
      if (arr_tag_we_s) begin
        tag_q[idx_s] <= tag_s;
      end
    end
  end

  // Main controller: request capture, FSM, valid bits and memory port
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state_q    <= ST_IDLE;
      req_v_q    <= 1'b0;
      req_addr_q <= {(AW-2){1'b0}};
      req_we_q   <= 1'b0;
      req_fm_q   <= 1'b0;
      wbuf_q     <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= {AW{1'b0}};
      valid_q    <= {LINES{1'b0}};
    end else begin
      // A new precycle is only taken when the core is not stalled; an enable
      // during a stall is a protocol violation and is dropped.
      if (!busy_s) begin
        req_v_q <= aexm_dcache_precycle_enable;
        if (aexm_dcache_precycle_enable) begin
          req_addr_q <= aexm_dcache_precycle_addr[AW-1:2];
          req_we_q   <= aexm_dcache_precycle_we;
          req_fm_q   <= aexm_dcache_force_miss;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (req_v_q) begin
            if (req_we_q) begin
              wbuf_q     <= aexm_dcache_datao;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {req_addr_q, 2'b00};
              state_q    <= ST_WRITE;
            end else if (rd_hit_s) begin
              // Remember the hit data so datai holds it across later writes
              rdata_q <= data_q[idx_s];
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_addr_q, 2'b00};
              state_q    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            valid_q[idx_s] <= 1'b1;
            rdata_q        <= mem_rdata;
            mem_req_q      <= 1'b0;
            state_q        <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Any enable seen here was already captured above; req_v_q
          // carries it into IDLE.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_dcache_resp.sv
module tb_aexm_dcache_resp;

  logic        clk;
  logic        rst_n;
  logic [31:0] p_addr;
  logic        p_en;
  logic        p_we;
  logic        p_fm;
  logic [31:0] datao;
  logic [31:0] datai;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp;
  int n_bad;

  // memory model controls
  logic        auto_ack;
  logic        manual_ack;
  logic        ack_auto;
  int          mem_lat;
  logic [31:0] rd_val;
  int          wait_cnt;
  int          req_cnt;
  logic [31:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;

  assign mem_ack = ack_auto | manual_ack;

  aexm_dcache_resp #(.IDX_W(6), .AW(32)) dut (
    .sys_clk_i                   (clk),
    .sys_rst_i                   (rst_n),
    .aexm_dcache_precycle_addr   (p_addr),
    .aexm_dcache_precycle_enable (p_en),
    .aexm_dcache_precycle_we     (p_we),
    .aexm_dcache_force_miss      (p_fm),
    .aexm_dcache_datao           (datao),
    .aexm_dcache_datai           (datai),
    .aexm_dcache_cache_busy      (busy),
    .mem_req                     (mem_req),
    .mem_we                      (mem_we),
    .mem_addr                    (mem_addr),
    .mem_wdata                   (mem_wdata),
    .mem_rdata                   (mem_rdata),
    .mem_ack                     (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory responder: acks a request in its mem_lat-th cycle
  initial begin
    ack_auto  = 1'b0;
    wait_cnt  = 0;
    req_cnt   = 0;
    mem_rdata = 32'h0;
    cap_addr  = 32'h0;
    cap_we    = 1'b0;
    cap_wdata = 32'h0;
  end

  always @(negedge clk) begin
    if (ack_auto) begin
      ack_auto = 1'b0;
    end else if (auto_ack && mem_req) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= mem_lat) begin
        ack_auto  = 1'b1;
        mem_rdata = rd_val;
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
        req_cnt   = req_cnt + 1;
        wait_cnt  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one access: precycle, then wait out busy; returns at the first non-busy negedge
  task automatic do_access(input logic [31:0] a, input logic we, input logic fm,
                           input logic [31:0] wd, output int busy_n,
                           output logic [31:0] di, output int nreq);
    int r0;
    r0 = req_cnt;
    @(negedge clk);
    p_addr = a; p_en = 1'b1; p_we = we; p_fm = fm; datao = wd;
    @(negedge clk);
    p_en = 1'b0; p_we = 1'b0; p_fm = 1'b0;
    busy_n = 0;
    while (busy && busy_n < 60) begin
      busy_n = busy_n + 1;
      @(negedge clk);
    end
    di   = datai;
    nreq = req_cnt - r0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        fm;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          exp_busy;
    logic [31:0] exp_datai;
    int          exp_nreq;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          bn;
    int          nr;
    int          r0;
    logic [31:0] di;

    n_cmp = 0; n_bad = 0;
    auto_ack = 1'b1; manual_ack = 1'b0; mem_lat = 3; rd_val = 32'h0;
    p_addr = 32'h0; p_en = 1'b0; p_we = 1'b0; p_fm = 1'b0; datao = 32'h0;

    //             addr          we    fm    wdata         rdata        lat busy datai        nreq
    vecs[0]  = '{32'h0000_0040, 1'b0, 1'b0, 32'h0,        32'hDEAD_BEEF, 3, 4, 32'hDEAD_BEEF, 1};
    vecs[1]  = '{32'h0000_0040, 1'b0, 1'b0, 32'h0,        32'h0,         3, 0, 32'hDEAD_BEEF, 0};
    vecs[2]  = '{32'h0000_0040, 1'b1, 1'b0, 32'h1234_5678, 32'h0,        3, 4, 32'hDEAD_BEEF, 1};
    vecs[3]  = '{32'h0000_0040, 1'b0, 1'b0, 32'h0,        32'h0,         3, 0, 32'h1234_5678, 0};
    vecs[4]  = '{32'h0000_0140, 1'b1, 1'b0, 32'hA5A5_0140, 32'h0,        3, 4, 32'h1234_5678, 1};
    vecs[5]  = '{32'h0000_0140, 1'b0, 1'b0, 32'h0,        32'hA5A5_0140, 3, 4, 32'hA5A5_0140, 1};
    vecs[6]  = '{32'h1000_0040, 1'b0, 1'b0, 32'h0,        32'h1111_2222, 1, 2, 32'h1111_2222, 1};
    vecs[7]  = '{32'h0000_0040, 1'b0, 1'b0, 32'h0,        32'h1234_5678, 3, 4, 32'h1234_5678, 1};
    vecs[8]  = '{32'h0000_0040, 1'b0, 1'b0, 32'h0,        32'h0,         3, 0, 32'h1234_5678, 0};
    vecs[9]  = '{32'h0000_0040, 1'b0, 1'b1, 32'h0,        32'hCAFE_0001, 3, 4, 32'hCAFE_0001, 1};
    vecs[10] = '{32'h0000_0040, 1'b0, 1'b0, 32'h0,        32'h0,         3, 0, 32'hCAFE_0001, 0};
    vecs[11] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        32'h0BAD_F00D, 3, 4, 32'h0BAD_F00D, 1};
    vecs[12] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        32'h0,         3, 0, 32'h0BAD_F00D, 0};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst datai", datai, 32'h0);
    check("rst mem_req", {31'h0, mem_req}, 32'h0);
    check("rst mem_we", {31'h0, mem_we}, 32'h0);
    rst_n = 1'b1;

    // table-driven accesses
    for (int i = 0; i < 13; i++) begin
      mem_lat = vecs[i].lat;
      rd_val  = vecs[i].rdata;
      do_access(vecs[i].addr, vecs[i].we, vecs[i].fm, vecs[i].wdata, bn, di, nr);
      check($sformatf("v%0d busy_cycles", i), 32'(bn), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d datai", i), di, vecs[i].exp_datai);
      check($sformatf("v%0d mem_reqs", i), 32'(nr), 32'(vecs[i].exp_nreq));
      if (vecs[i].exp_nreq == 1) begin
        check($sformatf("v%0d mem_addr", i), cap_addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d mem_we", i), {31'h0, cap_we}, {31'h0, vecs[i].we});
        if (vecs[i].we) begin
          check($sformatf("v%0d mem_wdata", i), cap_wdata, vecs[i].wdata);
        end
      end
    end

    // enable accepted in DONE: miss on 0x80, then immediate hit on the same line
    mem_lat = 2; rd_val = 32'h8080_8080;
    @(negedge clk);
    p_addr = 32'h0000_0080; p_en = 1'b1;
    @(negedge clk);
    p_en = 1'b0;
    bn = 0;
    while (busy && bn < 60) begin
      bn = bn + 1;
      @(negedge clk);
    end
    check("done busy_cycles", 32'(bn), 32'd3);
    check("done mem_req low", {31'h0, mem_req}, 32'h0);
    check("done datai", datai, 32'h8080_8080);
    r0 = req_cnt;
    p_addr = 32'h0000_0080; p_en = 1'b1;
    @(negedge clk);
    p_en = 1'b0;
    check("b2b busy", {31'h0, busy}, 32'h0);
    check("b2b datai", datai, 32'h8080_8080);
    @(negedge clk);
    check("b2b no req", 32'(req_cnt - r0), 32'h0);

    // reset in the middle of a fill, then a late ack
    auto_ack = 1'b0;
    @(negedge clk);
    p_addr = 32'h0000_0400; p_en = 1'b1;
    @(negedge clk);
    p_en = 1'b0;
    check("pre-rst busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("fill mem_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst busy", {31'h0, busy}, 32'h0);
    check("midrst datai", datai, 32'h0);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check("late ack mem_req", {31'h0, mem_req}, 32'h0);
    check("late ack busy", {31'h0, busy}, 32'h0);
    check("late ack datai", datai, 32'h0);
    auto_ack = 1'b1; mem_lat = 3; rd_val = 32'h5A5A_0040;
    do_access(32'h0000_0040, 1'b0, 1'b0, 32'h0, bn, di, nr);
    check("postrst busy_cycles", 32'(bn), 32'd4);
    check("postrst datai", di, 32'h5A5A_0040);
    check("postrst mem_reqs", 32'(nr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aexm_dcache_resp.md
Name: aexm_dcache_resp

Overview:
Cache-side responder for the core's data precycle interface. It accepts precycle address, enable and write-enable, answers read hits with zero stall, and fills misses over a req/ack memory port. It is direct-mapped with one 32-bit word per line, write-through and no-write-allocate. It sits between the core's dcache port and the memory fabric and drives datai and cache_busy.

Parameters:
IDX_W, 6, index width; the cache holds 2**IDX_W lines.
AW, 32, address width; tag is addr[AW-1:IDX_W+2].

Ports:
sys_clk_i  in  1  clock; all state changes on the rising edge.
sys_rst_i  in  1  synchronous reset, active-low (0 = reset).
aexm_dcache_precycle_addr  in  32  byte address for the next data phase; bits [1:0] are ignored.
aexm_dcache_precycle_enable  in  1  a request is presented this cycle.
aexm_dcache_precycle_we  in  1  the request is a write; qualified by enable.
aexm_dcache_force_miss  in  1  treat the read as a miss; qualified by enable.
aexm_dcache_datao  in  32  write data, sampled in the data phase.
aexm_dcache_datai  out  32  read data, valid in the data phase when busy=0.
aexm_dcache_cache_busy  out  1  stall; the core holds its data phase while this is 1.
mem_req  out  1  memory request; held until ack.
mem_we  out  1  memory write.
mem_addr  out  AW  word-aligned memory address.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data, valid with mem_ack.
mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Phases: a precycle in cycle N, with enable=1, registers addr, we and force_miss into the request registers and sets req_v. Cycle N+1 is the data phase.
- States: IDLE, FILL, WRITE, DONE.
- IDLE with req_v: hit = valid[idx] and tag match and not force_miss.
  - Read hit: datai = data[idx] combinationally; busy=0; req_v clears unless a new enable arrives.
  - Read miss: busy=1 combinationally in the same cycle; go to FILL.
  - Write, hit or miss: busy=1; capture datao into wbuf; on a hit, update data[idx] at that edge; go to WRITE.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {req_addr[AW-1:2],2'b00}; busy=1.
  - On mem_ack: write data[idx] = mem_rdata, tag[idx] = tag, valid[idx] = 1; load rdata_q = mem_rdata; go to DONE.
  - mem_req deasserts in the cycle after ack.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata = wbuf; busy=1.
  - On mem_ack: go to DONE. A write miss never allocates a line.
- DONE:
  - busy=0 for exactly one cycle.
  - datai = rdata_q after a fill; datai holds its last value after a write.
  - An enable in DONE is accepted as in IDLE; the next state is IDLE with req_v set.
- Enable while busy=1 is a protocol violation and is ignored.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss: busy for 1 + memory latency cycles, then DONE.
  - Write: the same as a read miss.
- force_miss on a hit line still performs a fill and overwrites the line with memory data.
- Writes are full word only; there are no byte enables.
- Index = addr[IDX_W+1:2]. Tag and index wrap naturally at the top of the address space.
- mem_ack outside FILL/WRITE is ignored.
- Reset (sys_rst_i=0 at an edge), including mid-FILL or mid-WRITE:
  - state=IDLE, req_v=0, all valid bits cleared, mem_req=0, mem_we=0.
  - datai=0, busy=0, rdata_q=0, wbuf=0.
  - Tag and data arrays are not cleared.
  - A late mem_ack after reset is ignored.
- Outputs are glitch-free relative to the clock. busy and datai are combinational only from registered state plus array reads.

Test Plan:
- Reset, then read 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles -> busy=1 for 4 cycles; mem_addr=0x40; DONE datai=0xDEAD_BEEF; busy=0.
- Read 0x40 again -> busy stays 0; datai=0xDEAD_BEEF in the data phase; no mem_req.
- Write 0x1234_5678 to 0x40 (hit) -> mem_req, mem_we=1, mem_wdata=0x1234_5678. After ack, a read of 0x40 hits with datai=0x1234_5678.
- Write to 0x0000_0140 (miss) -> memory written; a following read of 0x140 misses and fills.
- Read 0x1000_0040 (same index 16, different tag) -> miss with fill. A read of 0x40 then misses, showing eviction.
- Read 0x40 with force_miss=1 while the line is valid -> a fill occurs and datai equals the new mem_rdata 0xCAFE_0001.
- Assert reset during FILL, then ack arrives -> mem_req=0 after the edge; ack ignored; a read of 0x40 misses.
